// File: rtl/sobel_magnitude_if.sv
// Pixel stream bundle for sobel_magnitude.
//   din / blanking_in / validin     : upstream sample into the filter
//   dout / blanking_out / validout  : gradient magnitude out of the filter
// master = the side that feeds samples and receives results (source/sink),
// slave  = the filter itself.
interface sobel_magnitude_if;
    logic [7:0] din;
    logic       blanking_in;
    logic       validin;
    logic [7:0] dout;
    logic       blanking_out;
    logic       validout;

    modport master (
        output din, blanking_in, validin,
        input  dout, blanking_out, validout
    );

    modport slave (
        input  din, blanking_in, validin,
        output dout, blanking_out, validout
    );
endinterface

// File: rtl/sobel_magnitude.sv
// Sobel gradient magnitude over a 3x3 window of a raster pixel stream.
//   clock  : single clock, all state on the rising edge
//   reset  : synchronous, active high; clears counters, window and outputs
//   bus    : sobel_magnitude_if.slave
//            din/blanking_in/validin in, dout/blanking_out/validout out
// Two line buffers hold the previous two lines (pixel + blanking flag).
// The window shifts only on accepted samples, so validin=0 stalls every
// register. One arithmetic stage follows the window: dout for centre k
// appears the cycle after sample k+LINE_LEN+2 is accepted.
module sobel_magnitude #(
    parameter int LINE_LEN = 400,
    parameter int LB_AW    = 9
) (
    input  logic            clock,
    input  logic            reset,
    sobel_magnitude_if.slave bus
);
    localparam int CW = LB_AW + 2;
    localparam logic [LB_AW-1:0] LAST_COL = LB_AW'(LINE_LEN - 1);
    // sample index at which the window centre reaches k = 0
    localparam logic [CW-1:0] CNT_WIN = CW'(LINE_LEN + 1);
    // sample index at which the window centre passes the first line (k > LINE_LEN)
    localparam logic [CW-1:0] CNT_INT = CW'(2 * LINE_LEN + 2);

    logic              accept;
    logic [LB_AW-1:0]  col;
    logic [CW-1:0]     cnt;        // saturating sample index
    logic [8:0]        lb_a [LINE_LEN];  // previous line
    logic [8:0]        lb_b [LINE_LEN];  // line before that
    logic [8:0]        row0_in, row1_in, row2_in;
    logic [2:0][2:0][8:0] win;     // [row][col] of {blank, pixel}
    logic              win_vld;    // window holds a centre k >= 0
    logic              win_pmask;  // centre in first line or on a left/right edge
    logic [LB_AW-1:0]  ctr_col;

    logic signed [10:0] gx, gy;
    logic [10:0]       ax, ay;
    logic [11:0]       mag;
    logic              blk_any;
    logic [7:0]        dout_next;

    logic [7:0]        dout_r;
    logic              blank_r;
    logic              valid_r;

    assign accept  = bus.validin;
    assign row2_in = {bus.blanking_in, bus.din};
    // asynchronous reads ahead of the write edge give read-before-write
    assign row1_in = lb_a[col];
    assign row0_in = lb_b[col];

    // the centre lags the incoming sample by one line plus one column
    assign ctr_col = (col == '0) ? LAST_COL : col - 1'b1;

    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            lb_a[col] <= row2_in;
            lb_b[col] <= row1_in;
        end
    end

    function automatic logic signed [10:0] px(input logic [8:0] t);
        return signed'({3'b000, t[7:0]});
    endfunction

    always_comb begin
        gx = (px(win[0][2]) + (px(win[1][2]) <<< 1) + px(win[2][2]))
           - (px(win[0][0]) + (px(win[1][0]) <<< 1) + px(win[2][0]));
        gy = (px(win[2][0]) + (px(win[2][1]) <<< 1) + px(win[2][2]))
           - (px(win[0][0]) + (px(win[0][1]) <<< 1) + px(win[0][2]));
        ax = gx[10] ? 11'(-gx) : 11'(gx);
        ay = gy[10] ? 11'(-gy) : 11'(gy);
        mag = 12'(ax) + 12'(ay);
        blk_any = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                blk_any = blk_any | win[r][c][8];
            end
        end
        if (win_pmask || blk_any) dout_next = 8'd0;
        else if (mag > 12'd255)   dout_next = 8'hFF;
        else                      dout_next = mag[7:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col       <= '0;
            cnt       <= '0;
            win       <= '0;
            win_vld   <= 1'b0;
            win_pmask <= 1'b0;
            dout_r    <= 8'd0;
            blank_r   <= 1'b0;
            valid_r   <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (accept) begin
                col <= (col == LAST_COL) ? '0 : col + 1'b1;
                if (cnt != CNT_INT) cnt <= cnt + 1'b1;
                win[0][1:0] <= win[0][2:1];
                win[1][1:0] <= win[1][2:1];
                win[2][1:0] <= win[2][2:1];
                win[0][2]   <= row0_in;
                win[1][2]   <= row1_in;
                win[2][2]   <= row2_in;
                win_vld     <= (cnt >= CNT_WIN);
                win_pmask   <= (cnt < CNT_INT) || (ctr_col == '0) || (ctr_col == LAST_COL);
                // arithmetic stage consumes the window as it stood before this edge
                valid_r     <= win_vld;
                dout_r      <= dout_next;
                blank_r     <= win[1][1][8];
            end
        end
    end

    assign bus.dout         = dout_r;
    assign bus.blanking_out = blank_r;
    assign bus.validout     = valid_r;
endmodule

// File: tb/tb_sobel_magnitude.sv
// Bench for sobel_magnitude: a LINE_LEN=8 instance for the directed and
// random streams, and a LINE_LEN=400 instance for the blanking pattern.
// Accepted samples are logged per instance; expected outputs are computed
// directly from the logged samples with the Sobel formula.
module tb_sobel_magnitude;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sobel_magnitude_if bus_a ();
    sobel_magnitude_if bus_b ();

    sobel_magnitude #(.LINE_LEN(8), .LB_AW(3)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    sobel_magnitude #(.LINE_LEN(400), .LB_AW(9)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    int         llen [2] = '{8, 400};
    logic [8:0] hist [2][4096];
    int         ncnt [2] = '{0, 0};
    int         acc_n[2] = '{0, 0};
    bit         acc  [2] = '{1'b0, 1'b0};
    bit         rst_seen = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected magnitude for centre k, straight from the definition.
    function automatic int ref_dout(input int d, input int k);
        int L, c, gx, gy, v, m;
        L = llen[d];
        c = k % L;
        if (k <= L || c == 0 || c == L - 1) return 0;
        gx = 0;
        gy = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                logic [8:0] s;
                s = hist[d][k + dr * L + dc];
                if (s[8]) return 0;
                v = int'(s[7:0]);
                gx += ((dr == 0) ? 2 : 1) * dc * v;
                gy += ((dc == 0) ? 2 : 1) * dr * v;
            end
        end
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 255 : m;
    endfunction

    // log what each instance accepted on this edge
    always @(posedge clock) begin
        rst_seen = reset;
        acc[0] = 1'b0;
        acc[1] = 1'b0;
        if (reset) begin
            ncnt[0] = 0;
            ncnt[1] = 0;
        end else begin
            if (bus_a.validin) begin
                acc_n[0] = ncnt[0];
                if (ncnt[0] < 4096) hist[0][ncnt[0]] = {bus_a.blanking_in, bus_a.din};
                ncnt[0]++;
                acc[0] = 1'b1;
            end
            if (bus_b.validin) begin
                acc_n[1] = ncnt[1];
                if (ncnt[1] < 4096) hist[1][ncnt[1]] = {bus_b.blanking_in, bus_b.din};
                ncnt[1]++;
                acc[1] = 1'b1;
            end
        end
    end

    task automatic check_dut(input int d, input logic v, input logic [7:0] o, input logic b);
        int k;
        if (rst_seen) begin
            chk($sformatf("rst_valid[%0d]", d), int'(v), 0);
            chk($sformatf("rst_dout[%0d]", d), int'(o), 0);
            chk($sformatf("rst_blank[%0d]", d), int'(b), 0);
        end else if (acc[d] && acc_n[d] >= llen[d] + 2) begin
            k = acc_n[d] - llen[d] - 2;
            chk($sformatf("valid[%0d] k=%0d", d, k), int'(v), 1);
            chk($sformatf("dout[%0d] k=%0d", d, k), int'(o), ref_dout(d, k));
            chk($sformatf("blank[%0d] k=%0d", d, k), int'(b), int'(hist[d][k][8]));
        end else begin
            chk($sformatf("idle_valid[%0d]", d), int'(v), 0);
        end
    endtask

    always @(negedge clock) begin
        check_dut(0, bus_a.validout, bus_a.dout, bus_a.blanking_out);
        check_dut(1, bus_b.validout, bus_b.dout, bus_b.blanking_out);
    end

    task automatic drive(input int d, input bit v, input logic [7:0] p, input bit bl);
        @(negedge clock);
        reset = 1'b0;
        bus_a.validin = 1'b0;
        bus_b.validin = 1'b0;
        if (d == 0) begin
            bus_a.validin = v; bus_a.din = p; bus_a.blanking_in = bl;
        end else begin
            bus_b.validin = v; bus_b.din = p; bus_b.blanking_in = bl;
        end
    endtask

    // validin held high during reset to show it is ignored
    task automatic do_reset(input int cycles);
        @(negedge clock);
        reset = 1'b1;
        bus_a.validin = 1'b1;
        bus_b.validin = 1'b1;
        repeat (cycles - 1) @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        bus_a.din = 8'd0; bus_a.blanking_in = 1'b0; bus_a.validin = 1'b0;
        bus_b.din = 8'd0; bus_b.blanking_in = 1'b0; bus_b.validin = 1'b0;
        do_reset(3);

        // flat image, then a one-cycle reset at n=20 restarting the latency
        for (int n = 0; n < 20; n++) drive(0, 1'b1, 8'd100, 1'b0);
        do_reset(1);
        for (int n = 0; n < 30; n++) drive(0, 1'b1, 8'd100, 1'b0);

        // horizontal ramp: interior gives 80
        do_reset(2);
        for (int n = 0; n < 40; n++) drive(0, 1'b1, 8'(10 * (n % 8)), 1'b0);

        // same ramp with validin toggling 1,0,1,0
        do_reset(2);
        for (int n = 0; n < 40; n++) begin
            drive(0, 1'b1, 8'(10 * (n % 8)), 1'b0);
            drive(0, 1'b0, 8'($urandom), 1'b0);
        end

        // vertical step edge: saturates at col 3 and 4
        do_reset(2);
        for (int n = 0; n < 40; n++) drive(0, 1'b1, ((n % 8) < 4) ? 8'd0 : 8'd255, 1'b0);

        // random pixels, stalls, sparse blanking, occasional reset
        do_reset(2);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) do_reset(1);
            else drive(0, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0);
        end

        // full-width line with two blanking columns per line
        do_reset(2);
        for (int n = 0; n < 1700; n++)
            drive(1, 1'b1, 8'($urandom), (n > 0) && ((n % 400) < 2));

        repeat (3) drive(0, 1'b0, 8'd0, 1'b0);
        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sobel_magnitude.md
SOBEL_MAGNITUDE -- requirements
Module: sobel_magnitude

Interface
REQ-001 Parameter LINE_LEN, default 400, SHALL give pixel positions per line, blanking positions included.
REQ-002 Parameter LB_AW, default 9, SHALL give the line-buffer address width; ceil(log2(LINE_LEN)) <= LB_AW.
REQ-003 Port clock, input, 1: SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: SHALL be the synchronous, active-high reset.
REQ-005 Port din, input, 8: SHALL carry the unsigned smoothed pixel from the upstream five_by_five_window dout.
REQ-006 Port blanking_in, input, 1: SHALL mark din as a blanking position (data don't-care).
REQ-007 Port validin, input, 1: SHALL mark din/blanking_in as an accepted sample this cycle.
REQ-008 Port dout, output, 8: SHALL carry the saturated gradient magnitude.
REQ-009 Port blanking_out, output, 1: SHALL carry the blanking flag of the window-centre sample.
REQ-010 Port validout, output, 1: SHALL mark dout/blanking_out valid.

Function
REQ-011 A sample SHALL be accepted only on cycles with validin=1; with validin=0 every pipeline, line-buffer and counter register SHALL hold (stall), and the next-cycle validout SHALL be 0.
REQ-012 Accepted samples SHALL be indexed n=0,1,2,... from reset; column col(n) = n mod LINE_LEN, kept by a wrap counter, not a divider.
REQ-013 Two line buffers of LINE_LEN x 9 bits (pixel + blanking flag) plus a 3x3 register window SHALL give taps p[r][c], r,c in 0..2, row 2 and column 2 newest; the centre p[1][1] is sample k = n-LINE_LEN-1 when sample n is accepted.
REQ-014 Gx = (p02+2p12+p22)-(p00+2p10+p20) and Gy = (p20+2p21+p22)-(p00+2p01+p02) SHALL be computed as 11-bit signed values.
REQ-015 mag = |Gx|+|Gy| SHALL be computed at 12 bits unsigned; dout = 255 if mag > 255, else mag[7:0].
REQ-016 One registered arithmetic stage SHALL follow the window; the result for centre k SHALL appear on dout with validout=1 on the cycle after sample k+LINE_LEN+2 is accepted.
REQ-017 The first validout after reset SHALL therefore follow acceptance of sample LINE_LEN+2, and it SHALL carry centre k=0.
REQ-018 dout SHALL be forced to 0 for centre k when k <= LINE_LEN, col(k)=0, col(k)=LINE_LEN-1, or any of the 9 taps carries blanking flag 1.
REQ-019 blanking_out SHALL equal the blanking flag of centre k, aligned with dout.
REQ-020 Line-buffer read and write at the same address in one cycle SHALL return the old contents (read-before-write).
REQ-021 The wrap from col LINE_LEN-1 to 0 SHALL need no idle cycle, and no sample SHALL be dropped or duplicated across it.

Reset
REQ-022 While reset=1: dout=0, blanking_out=0 and validout=0 on the next edge.
REQ-023 Reset SHALL also clear the sample index, column counter, window registers and pipeline valid; line-buffer RAM contents need not be cleared, since REQ-018 masks them.
REQ-024 Reset mid-stream SHALL discard all in-flight samples; the first validout after release SHALL follow REQ-017 again.
REQ-025 validin=1 while reset=1 SHALL be ignored.

Verification
REQ-026 Bench LINE_LEN=8, continuous validin, constant din=100, no blanking -> validout first high after sample 10; every dout = 0.
REQ-027 LINE_LEN=8, din = 10*col -> dout = 80 for centres with k>8 and col 1..6; dout = 0 for col 0 and col 7.
REQ-028 LINE_LEN=8, din = 0 for col<4, 255 for col>=4 -> centres at col 3 and col 4 (k>8) give dout=255 (saturated, mag 1020); all other centres give 0.
REQ-029 REQ-027 stimulus with validin toggled 1,0,1,0 -> identical dout sequence on validout=1 cycles; validout=0 on every cycle that follows validin=0.
REQ-030 LINE_LEN=400, blanking_in=1 at n mod 400 in {0,1} for n>0 (as produced by five_by_five_window) -> blanking_out=1 for those centres; dout=0 for centres at col 399, 0, 1, 2.
REQ-031 Reset pulsed for 1 cycle at n=20 during REQ-026 -> validout=0 from the next cycle until 11 new samples have been accepted.
